// File: rtl/gol_edit_arbiter.sv
// gol_edit_arbiter
//   Owns the single write port of the MAX_X x MAX_Y cell-state store.
//   Two requesters share it:
//     - the generation engine (gen_req/gen_gnt/gen_done): one Conway step per grant
//     - the pattern stamper: writes a PAT_DIM x PAT_DIM pattern at the cursor,
//       one cell per cycle, with toroidal wrap-around
//   A pending stamp always wins over a generation request.
// Ports:
//   clk, rst          clock, synchronous active-low reset
//   freeze            hold off generation grants (stamps still run)
//   stamp_req         1-cycle stamp request; pattern_mat/cursor_x/cursor_y captured with it
//   gen_req/gen_done  engine handshake; gen_gnt is the grant level
//   wr_en/wr_addr/wr_data  stamp write port (addr = y*MAX_X + x), zeroed when idle
//   busy              state != IDLE
//   stamp_done        coincident with the last stamp write
//   stamp_err         pulse one cycle after an out-of-range stamp_req
module gol_edit_arbiter #(
  parameter int MAX_X   = 64,
  parameter int MAX_Y   = 48,
  parameter int PAT_DIM = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        stamp_req,
  input  logic [63:0] pattern_mat,
  input  logic [7:0]  cursor_x,
  input  logic [7:0]  cursor_y,
  input  logic        gen_req,
  input  logic        gen_done,
  output logic        gen_gnt,
  output logic        wr_en,
  output logic [11:0] wr_addr,
  output logic        wr_data,
  output logic        busy,
  output logic        stamp_done,
  output logic        stamp_err
);

  localparam int NCELL = PAT_DIM * PAT_DIM;
  localparam int KW    = $clog2(NCELL);
  localparam int CW    = $clog2(PAT_DIM);
  localparam int XW    = $clog2(MAX_X);
  localparam int YW    = $clog2(MAX_Y);

  typedef enum logic [1:0] {IDLE, STAMP, GEN} state_t;

  state_t             state_q, state_d;
  logic [KW-1:0]      k_q, k_d;
  logic [NCELL-1:0]   pat_q, pat_d;
  logic [XW-1:0]      cx_q, cx_d;
  logic [YW-1:0]      cy_q, cy_d;
  logic               slot_vld_q, slot_vld_d;
  logic [NCELL-1:0]   slot_pat_q, slot_pat_d;
  logic [XW-1:0]      slot_cx_q, slot_cx_d;
  logic [YW-1:0]      slot_cy_q, slot_cy_d;
  logic               err_q, err_d;

  logic               in_range, req_ok;
  logic [CW-1:0]      col;
  logic [KW-CW-1:0]   row;
  logic [XW:0]        xs, xw;
  logic [YW:0]        ys, yw;
  logic [11:0]        addr;

  assign in_range = (cursor_x < 8'(MAX_X)) && (cursor_y < 8'(MAX_Y));
  assign req_ok   = stamp_req && in_range;

  // Wrap by a single compare-and-subtract: origin < MAX and offset < PAT_DIM <= MAX,
  // so the sum is always below 2*MAX.
  assign col = k_q[CW-1:0];
  assign row = k_q[KW-1:CW];
  assign xs  = {1'b0, cx_q} + (XW+1)'(col);
  assign ys  = {1'b0, cy_q} + (YW+1)'(row);
  assign xw  = (xs >= (XW+1)'(MAX_X)) ? xs - (XW+1)'(MAX_X) : xs;
  assign yw  = (ys >= (YW+1)'(MAX_Y)) ? ys - (YW+1)'(MAX_Y) : ys;
  assign addr = 12'(yw) * 12'(MAX_X) + 12'(xw);

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    pat_d      = pat_q;
    cx_d       = cx_q;
    cy_d       = cy_q;
    slot_vld_d = slot_vld_q;
    slot_pat_d = slot_pat_q;
    slot_cx_d  = slot_cx_q;
    slot_cy_d  = slot_cy_q;
    err_d      = stamp_req && !in_range;

    // Requests arriving while busy park in the slot; newest overwrites.
    if (req_ok && state_q != IDLE) begin
      slot_vld_d = 1'b1;
      slot_pat_d = pattern_mat;
      slot_cx_d  = cursor_x[XW-1:0];
      slot_cy_d  = cursor_y[YW-1:0];
    end

    case (state_q)
      IDLE: begin
        // A request this cycle bypasses the slot so the first write lands next cycle.
        if (req_ok || slot_vld_q) begin
          state_d    = STAMP;
          k_d        = '0;
          pat_d      = req_ok ? pattern_mat       : slot_pat_q;
          cx_d       = req_ok ? cursor_x[XW-1:0]  : slot_cx_q;
          cy_d       = req_ok ? cursor_y[YW-1:0]  : slot_cy_q;
          slot_vld_d = 1'b0;
        end else if (gen_req && !freeze) begin
          state_d = GEN;
        end
      end
      STAMP: begin
        k_d = k_q + 1'b1;
        if (k_q == KW'(NCELL-1)) state_d = IDLE;
      end
      GEN: begin
        if (gen_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      k_q        <= '0;
      pat_q      <= '0;
      cx_q       <= '0;
      cy_q       <= '0;
      slot_vld_q <= 1'b0;
      slot_pat_q <= '0;
      slot_cx_q  <= '0;
      slot_cy_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      pat_q      <= pat_d;
      cx_q       <= cx_d;
      cy_q       <= cy_d;
      slot_vld_q <= slot_vld_d;
      slot_pat_q <= slot_pat_d;
      slot_cx_q  <= slot_cx_d;
      slot_cy_q  <= slot_cy_d;
      err_q      <= err_d;
    end
  end

  assign wr_en      = (state_q == STAMP);
  assign wr_addr    = wr_en ? addr : 12'd0;
  assign wr_data    = wr_en & pat_q[k_q];
  assign stamp_done = wr_en && (k_q == KW'(NCELL-1));
  assign gen_gnt    = (state_q == GEN);
  assign busy       = (state_q != IDLE);
  assign stamp_err  = err_q;

endmodule

// File: doc/gol_edit_arbiter.md
Name: gol_edit_arbiter

Overview:
- Owns the single write port of the 64x48 cell-state store and arbitrates it between two requesters.
- Requester 1 is the generation engine: one full Conway step per grant.
- Requester 2 is the pattern stamper: it writes the currently selected 8x8 keypad pattern into the grid at the cursor position, one cell per cycle.
- Sits between the input blocks (cursor, keypad pattern) and the state store/FSM.

Parameters:
- MAX_X, 64, grid width in cells
- MAX_Y, 48, grid height in cells
- PAT_DIM, 8, pattern edge length (pattern is PAT_DIM x PAT_DIM)

Ports:
- clk  input  1  system clock; the only clock
- rst  input  1  synchronous, active-low reset (sampled on rising clk; 0 = reset)
- freeze  input  1  1 = hold off generation grants; stamps still allowed
- stamp_req  input  1  single-cycle pulse: request a stamp
- pattern_mat  input  64  pattern bits; cell (r,c) = pattern_mat[r*8+c]
- cursor_x  input  8  stamp origin column
- cursor_y  input  8  stamp origin row
- gen_req  input  1  level; engine wants a step and holds it until granted
- gen_done  input  1  single-cycle pulse from engine: step finished
- gen_gnt  output  1  level; engine owns the store
- wr_en  output  1  stamp write strobe
- wr_addr  output  12  cell address = y*MAX_X + x
- wr_data  output  1  cell value written
- busy  output  1  high whenever state != IDLE
- stamp_done  output  1  pulse coincident with the last stamp write
- stamp_err  output  1  pulse: stamp rejected (cursor out of range)

Behaviour:
- Reset (rst=0 at an edge):
  - All outputs go to 0; state = IDLE; pending slot cleared.
  - Reset mid-STAMP or mid-GEN aborts immediately. No further writes; gen_gnt drops next edge.
- States: IDLE, STAMP, GEN.
- Capture:
  - A stamp_req sampled high latches pattern_mat, cursor_x and cursor_y into a one-deep pending slot.
  - A later stamp_req while the slot is full overwrites it (newest wins).
  - A stamp_req with cursor_x>=MAX_X or cursor_y>=MAX_Y is not latched. stamp_err pulses 1 cycle later.
- IDLE arbitration, evaluated each cycle:
  - If pending stamp: go to STAMP, clear slot. Stamp has priority over gen_req.
  - Else if gen_req && !freeze: go to GEN; gen_gnt=1 from the next cycle.
  - A stamp_req and gen_req arriving in the same cycle: stamp is served first, then GEN.
- STAMP:
  - Counter k=0..63 with r=k/8 and c=k%8.
  - Each cycle: wr_en=1, wr_data=pattern[r*8+c], x=(cx+c) mod MAX_X, y=(cy+r) mod MAX_Y.
  - Wrap-around is required; compute mod by a compare-and-subtract (no divider).
  - Overwrite semantics: 0 bits clear cells.
  - Latency: request sampled at edge N gives the first write in cycle N+1 and the last (k=63) in cycle N+64 with stamp_done=1. State is IDLE in cycle N+65.
  - A new stamp_req during STAMP goes to the pending slot. It is not merged into the stamp in progress.
- GEN:
  - gen_gnt held at 1, wr_en=0.
  - On gen_done sampled high: gen_gnt=0 the next cycle; return to IDLE.
  - freeze rising during GEN does not revoke the grant.
  - gen_done outside GEN is ignored.
- wr_addr and wr_data are 0 whenever wr_en=0.

Test Plan:
- Reset, then stamp_req with cursor (0,0) and pattern_mat=64'h1 -> 64 writes on addresses 0..7, 64..71, …, 448..455. Only addr 0 has wr_data=1. stamp_done at write 64; busy low the next cycle.
- Cursor (60,45), pattern all ones -> addresses wrap. Write k=4 hits x=0,y=45 (addr 2880). Write k=24 hits x=60,y=0 (addr 60). Write k=63 hits x=3,y=4 (addr 259).
- stamp_req and gen_req in the same cycle, freeze=0 -> full STAMP first, then gen_gnt=1 in cycle N+66. gen_done -> gen_gnt=0 the next cycle.
- freeze=1, gen_req held -> gen_gnt stays 0. Stamp still executes. Drop freeze -> grant follows in 1 cycle.
- During GEN, send two stamp_req pulses (patterns A then B), then gen_done -> exactly one stamp executes, using pattern B.
- cursor_y=48 -> stamp_err pulse, no writes. rst=0 at write k=10 -> wr_en=0 and all outputs 0 the next cycle.
